// File: rtl/lcd_text_buffer.sv
// 2x16 character store for the HD44780 display unit: printable bytes land at a cursor,
// control codes move the cursor, erase a character or start a 32-cycle clear sweep.
`timescale 1ns/1ps
module lcd_text_buffer #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter int         LINE_LEN   = 16
) (
    input  logic       clock500Hz,
    input  logic       reset,
    input  logic [4:0] i_char_index,
    output logic [7:0] o_phrase,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic [4:0] o_cursor,
    output logic       o_busy,
    output logic       o_wrapped
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [4:0] LINE_ADDR = 5'(LINE_LEN);
    localparam logic [4:0] LAST_ADDR = 5'd31;

    state_t     r_state;
    logic [7:0] r_buf [0:31];
    logic [4:0] r_cursor;
    logic [4:0] r_clrAddr;
    logic       r_busy;
    logic       r_wrapped;
    logic       w_accept;
    logic       w_printable;

    assign w_accept    = i_in_valid && (r_state == IDLE);
    assign w_printable = (i_in_data >= 8'h20) && (i_in_data <= 8'h7E);

    // The display unit reads straight from the registers, so a write shows up one edge later.
    assign o_phrase   = r_buf[i_char_index];
    assign o_in_ready = (r_state == IDLE);
    assign o_cursor   = r_cursor;
    assign o_busy     = r_busy;
    assign o_wrapped  = r_wrapped;

    always_ff @(posedge clock500Hz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_buf[i] <= BLANK_CHAR;
            end
            r_state   <= IDLE;
            r_cursor  <= 5'd0;
            r_clrAddr <= 5'd0;
            r_busy    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_buf[r_cursor] <= i_in_data;
                            r_cursor        <= r_cursor + 5'd1;
                            if (r_cursor == LAST_ADDR) begin
                                r_wrapped <= 1'b1;
                            end
                        end else if (i_in_data == 8'h0A) begin
                            // A newline on the second line falls back to the top of the display.
                            if (r_cursor < LINE_ADDR) begin
                                r_cursor <= LINE_ADDR;
                            end else begin
                                r_cursor  <= 5'd0;
                                r_wrapped <= 1'b1;
                            end
                        end else if (i_in_data == 8'h08) begin
                            if (r_cursor != 5'd0) begin
                                r_cursor                 <= r_cursor - 5'd1;
                                r_buf[r_cursor - 5'd1]   <= BLANK_CHAR;
                            end else begin
                                r_buf[0] <= BLANK_CHAR;
                            end
                        end else if (i_in_data == 8'h0C) begin
                            r_state   <= CLEAR;
                            r_clrAddr <= 5'd0;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    r_buf[r_clrAddr] <= BLANK_CHAR;
                    r_clrAddr        <= r_clrAddr + 5'd1;
                    if (r_clrAddr == LAST_ADDR) begin
                        r_state  <= IDLE;
                        r_cursor <= 5'd0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed and randomized checks of lcd_text_buffer against a character-array model
// of the display text and cursor.
`timescale 1ns/10ps
module tb_lcd_text_buffer;

    localparam logic [7:0] BLANK = 8'h20;

    logic       clock500Hz;
    logic       reset;
    logic [4:0] i_char_index;
    logic [7:0] o_phrase;
    logic       i_in_valid;
    logic [7:0] i_in_data;
    logic       o_in_ready;
    logic [4:0] o_cursor;
    logic       o_busy;
    logic       o_wrapped;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [32];
    int         mCursor;
    bit         mWrapped;

    lcd_text_buffer dut (
        .clock500Hz  (clock500Hz),
        .reset       (reset),
        .i_char_index(i_char_index),
        .o_phrase    (o_phrase),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_cursor    (o_cursor),
        .o_busy      (o_busy),
        .o_wrapped   (o_wrapped)
    );

    initial begin
        clock500Hz = 1'b0;
        forever #5 clock500Hz = ~clock500Hz;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Display text model: a plain array of characters plus a cursor position on a 32-cell ring.
    task automatic modelReset();
        for (int i = 0; i < 32; i++) mem[i] = BLANK;
        mCursor  = 0;
        mWrapped = 0;
    endtask

    task automatic modelApply(input logic [7:0] b);
        mWrapped = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mem[mCursor] = b;
            if (mCursor == 31) mWrapped = 1;
            mCursor = (mCursor + 1) % 32;
        end else if (b == 8'h0A) begin
            if (mCursor < 16) mCursor = 16;
            else begin
                mCursor  = 0;
                mWrapped = 1;
            end
        end else if (b == 8'h08) begin
            if (mCursor > 0) mCursor = mCursor - 1;
            mem[mCursor] = BLANK;
        end
    endtask

    task automatic checkBuffer(input string tag);
        @(negedge clock500Hz);
        for (int i = 0; i < 32; i++) begin
            i_char_index = 5'(i);
            #0.1;
            checkOutput($sformatf("%s[%0d]", tag, i), 32'(o_phrase), 32'(mem[i]));
        end
    endtask

    // One byte through the stream; the read port watches the cursor cell across the write edge.
    task automatic applyStimulus(input logic [7:0] b);
        int idx;
        @(negedge clock500Hz);
        idx          = mCursor;
        i_char_index = 5'(idx);
        i_in_valid   = 1'b1;
        i_in_data    = b;
        #1;
        checkOutput("readyBeforeAccept", 32'(o_in_ready), 32'd1);
        checkOutput("phraseBeforeWrite", 32'(o_phrase), 32'(mem[idx]));
        @(posedge clock500Hz);
        #1;
        i_in_valid = 1'b0;
        modelApply(b);
        checkOutput($sformatf("cursor after %0h", b), 32'(o_cursor), 32'(mCursor));
        checkOutput($sformatf("wrapped after %0h", b), 32'(o_wrapped), 32'(mWrapped));
        checkOutput("phraseAfterWrite", 32'(o_phrase), 32'(mem[idx]));
    endtask

    function automatic logic [7:0] randomByte();
        int sel;
        int v;
        sel = int'($urandom_range(0, 9));
        if (sel <= 5) return 8'($urandom_range(32, 126));
        if (sel == 6) return 8'h0A;
        if (sel == 7) return 8'h08;
        if (sel == 8) begin
            v = int'($urandom_range(0, 31));
            if (v == 8 || v == 10 || v == 12) v = 127;
            return 8'(v);
        end
        return 8'($urandom_range(127, 255));
    endfunction

    initial begin
        reset        = 1'b1;
        i_in_valid   = 1'b0;
        i_in_data    = 8'h00;
        i_char_index = 5'd0;
        modelReset();

        // Reset state
        repeat (2) @(negedge clock500Hz);
        checkOutput("resetCursor", 32'(o_cursor), 32'd0);
        checkOutput("resetBusy", 32'(o_busy), 32'd0);
        checkOutput("resetWrapped", 32'(o_wrapped), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("resetReady", 32'(o_in_ready), 32'd1);
        checkBuffer("resetBuf");

        // "HI"
        applyStimulus(8'h48);
        applyStimulus(8'h49);
        checkBuffer("hiBuf");

        // Newline from line 1 and from line 2
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyStimulus(8'h43);
        applyStimulus(8'h0A);
        applyStimulus(8'h0A);
        @(posedge clock500Hz);
        #1;
        checkOutput("wrappedOneCycle", 32'(o_wrapped), 32'd0);

        // 32 printable bytes fill the ring and wrap
        for (int i = 0; i < 32; i++) applyStimulus(8'(8'h41 + i));
        checkBuffer("fullBuf");
        @(posedge clock500Hz);
        #1;
        checkOutput("wrappedFullOneCycle", 32'(o_wrapped), 32'd0);

        // Backspace at cursor 0 blanks cell 0, then backspace from cursor 3
        applyStimulus(8'h08);
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        applyStimulus(8'h63);
        applyStimulus(8'h08);
        checkBuffer("bsBuf");

        // Randomized traffic, no form feeds
        for (int n = 0; n < 200; n++) begin
            applyStimulus(randomByte());
            if (n % 50 == 49) checkBuffer("randBuf");
        end

        // Form feed with 'Z' held behind it
        @(negedge clock500Hz);
        i_in_valid = 1'b1;
        i_in_data  = 8'h0C;
        #1;
        checkOutput("ffReady", 32'(o_in_ready), 32'd1);
        @(posedge clock500Hz);
        #1;
        i_in_data = 8'h5A;
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("sweepReady%0d", k), 32'(o_in_ready), 32'd0);
            checkOutput($sformatf("sweepBusy%0d", k), 32'(o_busy), 32'd1);
            checkOutput($sformatf("sweepWrapped%0d", k), 32'(o_wrapped), 32'd0);
            @(posedge clock500Hz);
            #1;
        end
        modelReset();
        checkOutput("postSweepReady", 32'(o_in_ready), 32'd1);
        checkOutput("postSweepBusy", 32'(o_busy), 32'd0);
        checkOutput("postSweepCursor", 32'(o_cursor), 32'd0);
        checkBuffer("clearBuf");
        @(posedge clock500Hz);
        #1;
        i_in_valid = 1'b0;
        modelApply(8'h5A);
        checkOutput("heldZCursor", 32'(o_cursor), 32'(mCursor));
        i_char_index = 5'd0;
        #0.1;
        checkOutput("heldZAt0", 32'(o_phrase), 32'h5A);

        // Reset during the sweep
        for (int i = 0; i < 20; i++) applyStimulus(8'(8'h30 + i));
        @(negedge clock500Hz);
        i_in_valid = 1'b1;
        i_in_data  = 8'h0C;
        @(posedge clock500Hz);
        #1;
        i_in_valid = 1'b0;
        repeat (9) @(posedge clock500Hz);
        #1;
        checkOutput("midSweepBusy", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("midResetCursor", 32'(o_cursor), 32'd0);
        checkOutput("midResetBusy", 32'(o_busy), 32'd0);
        checkOutput("midResetReady", 32'(o_in_ready), 32'd1);
        checkOutput("midResetWrapped", 32'(o_wrapped), 32'd0);
        @(negedge clock500Hz);
        reset = 1'b0;
        checkBuffer("midResetBuf");
        applyStimulus(8'h4F);
        applyStimulus(8'h4B);
        checkBuffer("afterResetBuf");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
